// File: rtl/top_pkg.sv
// Shared widths, mode bit positions and the divide-by-3 helper for the MOSFET evaluator.
// Optional build macro TOP_ROUND_EN switches every /3 to round half-up.
package top_pkg;

  localparam int unsigned OPW  = 3;
  localparam int unsigned RESW = 7;
  localparam int unsigned OUTW = 10;
  localparam int unsigned IW   = 10;

  localparam int unsigned MODE_ID_BIT    = 0;
  localparam int unsigned MODE_LARGE_BIT = 1;

  typedef logic [RESW-1:0] res_t;

  function automatic logic [IW-1:0] div3(input logic [IW-1:0] x);
`ifdef TOP_ROUND_EN
    return (x + IW'(1)) / IW'(3);
`else
    return x / IW'(3);
`endif
  endfunction

endpackage

// File: rtl/mos_calc.sv
// Single-device evaluator: drain current or transconductance from W, V_GS, V_DS.
// Division behaviour follows TOP_ROUND_EN through top_pkg::div3.
module mos_calc
  import top_pkg::*;
(
  input  logic [OPW-1:0] W,
  input  logic [OPW-1:0] V_GS,
  input  logic [OPW-1:0] V_DS,
  input  logic           sel_id,
  output res_t           result
);

  logic [IW-1:0] w_e, vgs_e, vds_e, vov;
  logic [IW-1:0] id_x, gm_x, sel_x;
  logic          triode;

  always_comb begin
    w_e    = IW'(W);
    vgs_e  = IW'(V_GS);
    vds_e  = IW'(V_DS);
    vov    = vgs_e - IW'(1);
    triode = vov > vds_e;

    // Triode branch only taken when Vov > V_DS, so the subtraction never goes negative.
    if (triode) begin
      id_x = w_e * (((vov * vds_e) << 1) - (vds_e * vds_e));
      gm_x = (w_e * vds_e) << 1;
    end else begin
      id_x = w_e * vov * vov;
      gm_x = (w_e * vov) << 1;
    end

    sel_x  = sel_id ? id_x : gm_x;
    result = (V_GS == '0) ? '0 : RESW'(div3(sel_x));
  end

endmodule

// File: rtl/top.sv
// Six-device gm / I_D evaluator: per-device compute, descending sort, weighted
// reduction of the larger or smaller half, one register stage. Honours TOP_ROUND_EN.
module top
  import top_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [1:0]      mode,
  input  logic [OPW-1:0]  W_0, W_1, W_2, W_3, W_4, W_5,
  input  logic [OPW-1:0]  V_GS_0, V_GS_1, V_GS_2, V_GS_3, V_GS_4, V_GS_5,
  input  logic [OPW-1:0]  V_DS_0, V_DS_1, V_DS_2, V_DS_3, V_DS_4, V_DS_5,
  output logic            out_valid,
  output logic [OUTW-1:0] out_n
);

  logic [OPW-1:0] w   [6];
  logic [OPW-1:0] vgs [6];
  logic [OPW-1:0] vds [6];
  res_t           res [6];
  res_t           srt [6];
  res_t           tmp;
  logic [OUTW-1:0] a, b, c, sum;

  assign w   = '{W_0, W_1, W_2, W_3, W_4, W_5};
  assign vgs = '{V_GS_0, V_GS_1, V_GS_2, V_GS_3, V_GS_4, V_GS_5};
  assign vds = '{V_DS_0, V_DS_1, V_DS_2, V_DS_3, V_DS_4, V_DS_5};

  for (genvar g = 0; g < 6; g++) begin : g_dev
    mos_calc u_calc (
      .W      (w[g]),
      .V_GS   (vgs[g]),
      .V_DS   (vds[g]),
      .sel_id (mode[MODE_ID_BIT]),
      .result (res[g])
    );
  end

  // Bubble network, descending; equal values are left in place.
  always_comb begin
    tmp = '0;
    srt = res;
    for (int unsigned i = 0; i < 5; i++) begin
      for (int unsigned j = 0; j < 5 - i; j++) begin
        if (srt[j] < srt[j+1]) begin
          tmp      = srt[j];
          srt[j]   = srt[j+1];
          srt[j+1] = tmp;
        end
      end
    end
  end

  always_comb begin
    if (mode[MODE_LARGE_BIT]) begin
      a = OUTW'(srt[0]);
      b = OUTW'(srt[1]);
      c = OUTW'(srt[2]);
    end else begin
      a = OUTW'(srt[3]);
      b = OUTW'(srt[4]);
      c = OUTW'(srt[5]);
    end
    if (mode[MODE_ID_BIT])
      sum = (a << 1) + a + (b << 2) + (c << 2) + c;
    else
      sum = a + b + c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_n     <= '0;
    end else if (in_valid) begin
      out_valid <= 1'b1;
      out_n     <= sum;
    end else begin
      out_valid <= 1'b0;
      out_n     <= '0;
    end
  end

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: directed set-A / corner cases plus randomized
// operands against a behavioural model (sort-and-weight with plain integers).
module tb_top;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] mode;
  logic [2:0] w   [6];
  logic [2:0] vgs [6];
  logic [2:0] vds [6];
  logic       out_valid;
  logic [9:0] out_n;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  top dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode),
    .W_0(w[0]), .W_1(w[1]), .W_2(w[2]), .W_3(w[3]), .W_4(w[4]), .W_5(w[5]),
    .V_GS_0(vgs[0]), .V_GS_1(vgs[1]), .V_GS_2(vgs[2]),
    .V_GS_3(vgs[3]), .V_GS_4(vgs[4]), .V_GS_5(vgs[5]),
    .V_DS_0(vds[0]), .V_DS_1(vds[1]), .V_DS_2(vds[2]),
    .V_DS_3(vds[3]), .V_DS_4(vds[4]), .V_DS_5(vds[5]),
    .out_valid(out_valid), .out_n(out_n)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int div3(input int x);
`ifdef TOP_ROUND_EN
    return (x + 1) / 3;
`else
    return x / 3;
`endif
  endfunction

  function automatic int dev(input int wi, input int vg, input int vd, input bit id);
    int vov;
    if (vg == 0) return 0;
    vov = vg - 1;
    if (vov > vd)
      return div3(id ? wi * (2 * vov * vd - vd * vd) : 2 * wi * vd);
    return div3(id ? wi * vov * vov : 2 * wi * vov);
  endfunction

  function automatic int model(input bit [1:0] m);
    int q[$];
    int base;
    for (int i = 0; i < 6; i++) q.push_back(dev(w[i], vgs[i], vds[i], m[0]));
    q.rsort();
    base = m[1] ? 0 : 3;
    if (m[0]) return 3 * q[base] + 4 * q[base+1] + 5 * q[base+2];
    return q[base] + q[base+1] + q[base+2];
  endfunction

  // One clock: apply inputs now, check the registered result just after the edge.
  task automatic step(input bit v, input bit r, input bit [1:0] m,
                      input string tag, input int exp_n);
    rst_n    = r;
    in_valid = v;
    mode     = m;
    @(posedge clk);
    #1;
    check({tag, "_valid"}, int'(out_valid), (r && v) ? 1 : 0);
    check({tag, "_n"}, int'(out_n), (r && v) ? exp_n : 0);
  endtask

  task automatic load_set_a();
    int sa [6][3] = '{'{7,3,5}, '{7,3,1}, '{6,4,3}, '{6,1,4}, '{7,2,1}, '{3,7,7}};
    for (int i = 0; i < 6; i++) begin
      w[i] = 3'(sa[i][0]); vgs[i] = 3'(sa[i][1]); vds[i] = 3'(sa[i][2]);
    end
  endtask

  task automatic load_all(input int wi, input int vg, input int vd);
    for (int i = 0; i < 6; i++) begin
      w[i] = 3'(wi); vgs[i] = 3'(vg); vds[i] = 3'(vd);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; mode = 2'b00;
    load_set_a();
    @(negedge clk);
    step(1'b0, 1'b0, 2'b00, "reset", 0);
    step(1'b0, 1'b1, 2'b00, "idle", 0);

`ifndef TOP_ROUND_EN
    step(1'b1, 1'b1, 2'b00, "setA_gm_small", 8);
    step(1'b1, 1'b1, 2'b10, "setA_gm_large", 33);
    step(1'b1, 1'b1, 2'b01, "setA_id_small", 29);
    step(1'b1, 1'b1, 2'b11, "setA_id_large", 225);
    step(1'b0, 1'b1, 2'b11, "drop_valid", 0);
    step(1'b1, 1'b1, 2'b00, "b2b_0", 8);
    step(1'b1, 1'b1, 2'b01, "b2b_1", 29);
    step(1'b1, 1'b1, 2'b11, "b2b_2", 225);
    step(1'b1, 1'b0, 2'b11, "reset_over_valid", 0);
    load_all(7, 7, 7);
    step(1'b1, 1'b1, 2'b11, "max_id", 1008);
    step(1'b1, 1'b1, 2'b10, "max_gm", 84);
`endif

    load_all(5, 0, 3);
    for (int m = 0; m < 4; m++) step(1'b1, 1'b1, 2'(m), "cutoff", 0);

    load_set_a();
    for (int m = 0; m < 4; m++) step(1'b1, 1'b1, 2'(m), "setA_model", model(2'(m)));

    for (int k = 0; k < 300; k++) begin
      bit [1:0] m;
      bit       v, r;
      for (int i = 0; i < 6; i++) begin
        w[i]   = 3'($urandom_range(7));
        vgs[i] = 3'($urandom_range(7));
        vds[i] = 3'($urandom_range(7));
      end
      m = 2'($urandom_range(3));
      v = ($urandom_range(9) != 0);
      r = ($urandom_range(19) != 0);
      step(v, r, m, "rnd", model(m));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/top.md
Name: top

Overview:
- Combinational MOSFET current/transconductance evaluator with a registered output stage.
- Computes drain current (I_D) or transconductance (gm) for six transistors from 3-bit W, V_GS and V_DS operands.
- Sorts the six results in descending order.
- Reduces either the larger or the smaller three to one 10-bit value.
- Sits as a leaf compute block; the upstream stage drives one operand set per valid cycle.

Parameters:
- none (all widths fixed: operands 3 bits, per-device result 7 bits, out_n 10 bits)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand set valid this cycle
- mode  input  2  mode[0]: 0=gm, 1=I_D; mode[1]: 0=smaller three, 1=larger three
- W_0..W_5  input  3 each  channel width, unsigned
- V_GS_0..V_GS_5  input  3 each  gate-source voltage, unsigned
- V_DS_0..V_DS_5  input  3 each  drain-source voltage, unsigned
- out_valid  output  1  out_n valid
- out_n  output  10  reduced result, unsigned

Behaviour:
- Reset: when rst_n=0 at a rising edge, out_valid<=0 and out_n<=0.
- Latency: exactly 1 cycle. Inputs sampled at edge k with in_valid=1 give out_valid=1 and the result at edge k+1.
- in_valid=0: out_valid<=0 and out_n<=0 at the next edge.
- Back-to-back valid inputs are accepted every cycle; there is no backpressure.
- Reset overrides in_valid.
- Per device i, all arithmetic is unsigned with floor division by 3:
  - Vov = V_GS-1.
  - V_GS=0: cutoff, I_D=gm=0.
  - Triode when Vov > V_DS: I_D = W*(2*Vov*V_DS - V_DS^2)/3; gm = 2*W*V_DS/3.
  - Saturation otherwise: I_D = W*Vov^2/3; gm = 2*W*Vov/3.
- Compute intermediates at ≥9-bit width before division; results fit in 7 bits (max I_D 84, max gm 28).
- Sort the six selected results descending: n0>=n1>=...>=n5. Ties are stable; order among equal values does not matter.
- Reduction:
  - gm, larger: n0+n1+n2.
  - gm, smaller: n3+n4+n5.
  - I_D, larger: 3*n0+4*n1+5*n2.
  - I_D, smaller: 3*n3+4*n4+5*n5.
- Maximum result is 1008, so out_n never overflows 10 bits.
- mode is sampled with the operands in the same cycle.

Optional Feature:
- Macro: TOP_ROUND_EN
- Defined: every /3 rounds half-up, computed as (x+1)/3 before the sort.
- Undefined: floor division as specified above.
- All Test Plan values assume the macro is undefined.

Decomposition:
- Package top_pkg holds:
  - width constants: OPW=3, RESW=7, OUTW=10.
  - mode bit indices: MODE_ID_BIT=0, MODE_LARGE_BIT=1.
  - a typedef for the 7-bit per-device result.
- Sub-module mos_calc (6 instances): inputs W, V_GS, V_DS, sel_id; output one 7-bit result.
- Sorting network and weighted reduction stay in top.

Test Plan:
- Operand set A = (W,V_GS,V_DS) per device 0..5: (7,3,5),(7,3,1),(6,4,3),(6,1,4),(7,2,1),(3,7,7).
  - gm per device: 9,4,12,0,4,12.
  - I_D per device: 9,7,18,0,2,36.
- Set A, mode=00 -> out_n=8 (4+4+0), out_valid=1 one cycle later.
- Set A, mode=10 -> out_n=33. Set A, mode=01 -> out_n=29. Set A, mode=11 -> out_n=225.
- All devices (7,7,7), mode=11 -> I_D=84 each, out_n=1008.
- All devices (7,7,7), mode=10 -> gm=28 each, out_n=84.
- All V_GS=0, any mode -> out_n=0.
- Assert rst_n=0 while in_valid=1 -> out_valid=0, out_n=0 next edge.
- Three consecutive valid cycles (set A with modes 00, 01, 11) -> outputs 8, 29, 225 on consecutive cycles.
